// File: rtl/seq_pkg.sv
// seq_pkg: shared definitions for the serial sequence generator.
// Provides the default widths, the two FSM state codes and the
// effective-length clamp used when a pattern is latched.
package seq_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int IDX_W_DEF = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // A length of zero, or one longer than the pattern register, means "whole pattern".
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned pat_w);
        return (len == 0 || len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/serial_seq_gen_if.sv
// serial_seq_gen_if: control and stream signals of the serial sequence generator.
// master drives start/pattern/len/rpt/hold/stop and receives the stream
// (x, x_valid, busy, done, bit_idx); slave is the generator side.
interface serial_seq_gen_if #(
    parameter int PAT_W = 8,
    parameter int IDX_W = 3
);
    logic             start;
    logic [PAT_W-1:0] pattern;
    logic [IDX_W:0]   len;
    logic             rpt;
    logic             hold;
    logic             stop;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] bit_idx;

    modport master (
        output start, pattern, len, rpt, hold, stop,
        input  x, x_valid, busy, done, bit_idx
    );

    modport slave (
        input  start, pattern, len, rpt, hold, stop,
        output x, x_valid, busy, done, bit_idx
    );
endinterface

// File: rtl/seq_shift_core.sv
// seq_shift_core: pattern register plus loadable down-counting bit index with wrap.
// Ports: clk, rst_n (async active-low); load latches pattern and len_eff and
// points the index at len_eff-1; adv steps the index down, wrapping to len_eff-1
// after 0; clr parks the index at 0. bit_o is the selected pattern bit, idx_o the
// current index and idx_next_o the index that the next edge will load.
module seq_shift_core
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             adv,
    input  logic             clr,
    input  logic [PAT_W-1:0] pattern,
    input  logic [IDX_W:0]   len_eff,
    output logic             bit_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [IDX_W-1:0] idx_next_o
);

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] top_q, top_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        pat_d = load ? pattern : pat_q;
        top_d = load ? IDX_W'(len_eff - 1'b1) : top_q;
        idx_d = load ? IDX_W'(len_eff - 1'b1)
              : clr  ? '0
              : adv  ? ((idx_q == '0) ? top_q : idx_q - 1'b1)
              : idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
            top_q <= '0;
            idx_q <= '0;
        end else begin
            pat_q <= pat_d;
            top_q <= top_d;
            idx_q <= idx_d;
        end
    end

    assign bit_o      = pat_q[idx_q];
    assign idx_o      = idx_q;
    assign idx_next_o = idx_d;

endmodule

// File: rtl/serial_seq_gen.sv
// serial_seq_gen: serial bit-stream transmitter, MSB-first with valid, stall, repeat and abort.
// Ports: clk, rst_n (async active-low) and bus (serial_seq_gen_if.slave):
// start/pattern/len/rpt latch a new stream in IDLE, hold stalls, stop aborts;
// x/x_valid carry the stream, busy marks SHIFT, done pulses with the last bit of
// a non-repeating pass, bit_idx counts down from len-1 to 0.
module serial_seq_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input logic              clk,
    input logic              rst_n,
    serial_seq_gen_if.slave  bus
);

    localparam int L_W = IDX_W + 1;

    logic [0:0]       state_q, state_d;
    logic             rpt_q, rpt_d;
    logic             done_q, done_d;
    logic             shift, last, load, adv, clr, finish;
    logic [L_W-1:0]   len_eff;
    logic             core_bit;
    logic [IDX_W-1:0] core_idx, core_idx_next;

    always_comb begin
        shift   = state_q == ST_SHIFT;
        last    = core_idx == '0;
        len_eff = L_W'(eff_len(32'(bus.len), PAT_W));
        load    = !shift && bus.start && !bus.stop;
        finish  = shift && !bus.stop && !bus.hold && last && !rpt_q;
        adv     = shift && !bus.stop && !bus.hold && !finish;
        clr     = (shift && bus.stop) || finish;
        state_d = load ? ST_SHIFT : (clr ? ST_IDLE : state_q);
        rpt_d   = load ? bus.rpt : rpt_q;
        // done marks only the edge that first presents bit 0; a held last bit clears it.
        done_d  = (load || adv) && core_idx_next == '0 && !rpt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rpt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rpt_q   <= rpt_d;
            done_q  <= done_d;
        end
    end

    seq_shift_core #(
        .PAT_W (PAT_W),
        .IDX_W (IDX_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .adv        (adv),
        .clr        (clr),
        .pattern    (bus.pattern),
        .len_eff    (len_eff),
        .bit_o      (core_bit),
        .idx_o      (core_idx),
        .idx_next_o (core_idx_next)
    );

    // Outputs are pure functions of flops; the index is parked at 0 whenever idle.
    assign bus.x       = shift && core_bit;
    assign bus.x_valid = shift;
    assign bus.busy    = shift;
    assign bus.done    = done_q;
    assign bus.bit_idx = core_idx;

endmodule

// File: tb/tb_serial_seq_gen.sv
// tb_serial_seq_gen: randomized and directed checks of serial_seq_gen against a bit-queue model.
module tb_serial_seq_gen;

    localparam int PAT_W = 8;
    localparam int IDX_W = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    serial_seq_gen_if #(.PAT_W(PAT_W), .IDX_W(IDX_W)) bus ();

    serial_seq_gen #(.PAT_W(PAT_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: the bits still to be shown in this pass, front = bit on x now.
    bit             mq[$];
    bit             m_rpt;
    bit             m_fresh;
    int             m_len;
    logic [PAT_W-1:0] m_pat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff(input int len);
        return (len == 0 || len > PAT_W) ? PAT_W : len;
    endfunction

    task automatic refill();
        for (int i = m_len - 1; i >= 0; i--) mq.push_back(m_pat[i]);
    endtask

    task automatic model_edge();
        if (mq.size() == 0) begin
            if (bus.start && !bus.stop) begin
                m_pat = bus.pattern;
                m_len = eff(int'(bus.len));
                m_rpt = bus.rpt;
                refill();
                m_fresh = 1;
            end
        end else if (bus.stop) begin
            mq.delete();
        end else if (bus.hold) begin
            m_fresh = 0;
        end else begin
            void'(mq.pop_front());
            if (mq.size() == 0 && m_rpt) refill();
            m_fresh = 1;
        end
    endtask

    task automatic check_outputs();
        bit act;
        act = mq.size() != 0;
        check("x", bus.x, act ? mq[0] : 1'b0);
        check("x_valid", bus.x_valid, act);
        check("busy", bus.busy, act);
        check("bit_idx", bus.bit_idx, act ? mq.size() - 1 : 0);
        check("done", bus.done, act && mq.size() == 1 && !m_rpt && m_fresh);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst_n) mq.delete();
        else model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_in();
        bus.start = 0;
        bus.hold  = 0;
        bus.stop  = 0;
        bus.rpt   = 0;
    endtask

    task automatic launch(input logic [PAT_W-1:0] pat, input int len, input bit rpt);
        bus.pattern = pat;
        bus.len     = (IDX_W+1)'(len);
        bus.rpt     = rpt;
        bus.start   = 1;
        cycle();
        bus.start   = 0;
    endtask

    task automatic run_count(input int len, output int nbits, output int ndone);
        nbits = 0;
        ndone = 0;
        launch(8'hA5, len, 0);
        for (int i = 0; i < 40 && bus.x_valid; i++) begin
            nbits += 1;
            ndone += int'(bus.done);
            cycle();
        end
    endtask

    initial begin
        logic [7:0] seq;
        int         dn, nb;
        idle_in();
        bus.pattern = '0;
        bus.len     = '0;
        repeat (2) cycle();
        #3 rst_n = 1;
        cycle();

        // Full 8-bit pass
        launch(8'b0110_1010, 8, 0);
        seq = 0;
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            seq = {seq[6:0], bus.x};
            dn += int'(bus.done);
            if (i < 7) cycle();
        end
        check("t1_seq", seq, 8'b0110_1010);
        check("t1_done", dn, 1);
        cycle();
        check("t1_end_valid", bus.x_valid, 0);

        // Repeat mode, 3 bits, stopped after 7 bits
        launch(8'b0000_0101, 3, 1);
        seq = 0;
        dn = 0;
        for (int i = 0; i < 7; i++) begin
            seq = {seq[6:0], bus.x};
            dn += int'(bus.done);
            if (i < 6) cycle();
        end
        check("t2_seq", seq[6:0], 7'b1011011);
        check("t2_done", dn, 0);
        bus.stop = 1;
        cycle();
        bus.stop = 0;
        check("t2_stop_valid", bus.x_valid, 0);

        // Hold for 3 cycles on bit_idx 2
        launch(8'b0001_1010, 5, 0);
        dn = int'(bus.done);
        cycle();
        cycle();
        check("t3_idx2", bus.bit_idx, 2);
        bus.hold = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t3_hold_x", {bus.x_valid, bus.x}, 2'b10);
        end
        bus.hold = 0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            dn += int'(bus.done);
        end
        check("t3_done", dn, 1);
        cycle();

        // Clamped lengths and the single-bit pass
        run_count(0, nb, dn);
        check("t4_len0_bits", nb, 8);
        run_count(12, nb, dn);
        check("t4_len12_bits", nb, 8);
        check("t4_len12_done", dn, 1);
        launch(8'b0000_0001, 1, 0);
        check("t4_len1", {bus.x_valid, bus.x, bus.done}, 3'b111);
        cycle();
        check("t4_len1_end", bus.x_valid, 0);

        // Asynchronous reset mid-stream
        launch(8'hFF, 8, 0);
        repeat (3) cycle();
        check("t5_idx4", bus.bit_idx, 4);
        #3 rst_n = 0;
        #1;
        mq.delete();
        check_outputs();
        check("t5_async", {bus.x, bus.x_valid, bus.busy, bus.done, bus.bit_idx}, 0);
        cycle();
        #3 rst_n = 1;
        repeat (2) cycle();

        // start while busy, stop+start while idle
        launch(8'b1100_0011, 4, 0);
        bus.pattern = 8'hFF;
        bus.len     = 2;
        bus.start   = 1;
        cycle();
        bus.start   = 0;
        repeat (4) cycle();
        check("t6_done_idle", bus.busy, 0);
        bus.start = 1;
        bus.stop  = 1;
        cycle();
        check("t6_stop_start", bus.busy, 0);
        idle_in();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.start   = $urandom_range(0, 3) == 0;
            bus.hold    = $urandom_range(0, 4) == 0;
            bus.stop    = $urandom_range(0, 40) == 0;
            bus.rpt     = $urandom_range(0, 3) == 0;
            bus.len     = (IDX_W+1)'($urandom_range(0, 15));
            bus.pattern = PAT_W'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
